// File: rtl/tern_pkg.sv
// Shared ternary definitions: trit codes, scheduler FSM states, trit NAND.
package tern_pkg;

    localparam logic [1:0] T0 = 2'b00;
    localparam logic [1:0] T1 = 2'b01;
    localparam logic [1:0] T2 = 2'b10;
    localparam logic [1:0] TX = 2'b11;  // invalid code, propagated as-is

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Ternary NAND: C = 2 - min(A,B); any invalid operand yields TX.
    function automatic logic [1:0] trit_nand(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] m;
        m = (a < b) ? a : b;
        if (a == TX || b == TX)
            return TX;
        return T2 - m;
    endfunction

endpackage

// File: rtl/nandgate.sv
// Combinational single-trit ternary NAND cell with invalid-code flag.
module nandgate
    import tern_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [1:0] y,
    output logic       err
);

    assign y   = trit_nand(a, b);
    assign err = (a == TX) || (b == TX);

endmodule

// File: rtl/tnand_sched.sv
// Round-robin scheduler sharing one ternary NAND cell among N_REQ requesters,
// processing one trit per cycle.
module tnand_sched
    import tern_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int TRITS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*2*TRITS-1:0] req_a,
    input  logic [N_REQ*2*TRITS-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [2:0]               rsp_id,
    output logic [2*TRITS-1:0]       rsp_data,
    output logic                     rsp_err
);

    localparam int             W      = 2 * TRITS;
    localparam int             KW     = (TRITS > 1) ? $clog2(TRITS) : 1;
    localparam logic [KW-1:0]  K_LAST = KW'(TRITS - 1);
    localparam logic [2:0]     LG_RST = 3'(N_REQ - 1);

    state_t         state, state_nx;
    logic [2:0]     last_grant;
    logic [2:0]     pick;
    logic           pick_any;
    logic [W-1:0]   sel_a, sel_b;
    logic [W-1:0]   op_a, op_b, res;
    logic           err_r;
    logic [KW-1:0]  k;
    logic [2:0]     id;
    logic [1:0]     cell_y;
    logic           cell_err;

    // Round-robin pick: scan offsets high to low so the nearest requester after last_grant wins.
    always_comb begin
        pick     = '0;
        pick_any = 1'b0;
        for (int off = N_REQ; off >= 1; off--) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && i == (int'(last_grant) + off) % N_REQ) begin
                    pick     = 3'(i);
                    pick_any = 1'b1;
                end
            end
        end
    end

    // Operand mux for the picked requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick == 3'(i)) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
    end

    // The single shared NAND cell, fed the current trit of the captured operands.
    nandgate u_cell (
        .a   (op_a[2*k +: 2]),
        .b   (op_b[2*k +: 2]),
        .y   (cell_y),
        .err (cell_err)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic and grant strobe; ready is also gated by reset so it drops at once.
    always_comb begin
        state_nx  = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nx = RUN;
                    for (int i = 0; i < N_REQ; i++)
                        req_ready[i] = rst_n && (pick == 3'(i));
                end
            end
            RUN:     if (k == K_LAST) state_nx = RESP;
            RESP:    if (rsp_ready)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, build result trit by trit, update priority on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            res        <= '0;
            err_r      <= 1'b0;
            k          <= '0;
            id         <= '0;
            last_grant <= LG_RST;
        end else begin
            case (state)
                IDLE: if (pick_any) begin
                    op_a  <= sel_a;
                    op_b  <= sel_b;
                    res   <= '0;
                    err_r <= 1'b0;
                    k     <= '0;
                    id    <= pick;
                end
                RUN: begin
                    res[2*k +: 2] <= cell_y;
                    err_r         <= err_r | cell_err;
                    k             <= k + 1'b1;
                end
                RESP: if (rsp_ready) last_grant <= id;
                default: ;
            endcase
        end
    end

    // Response outputs read zero outside RESP.
    assign rsp_valid = (state == RESP);
    assign rsp_data  = rsp_valid ? res   : '0;
    assign rsp_err   = rsp_valid ? err_r : 1'b0;
    assign rsp_id    = rsp_valid ? id    : 3'd0;

endmodule

// File: tb/tb_tnand_sched.sv
// Directed bench for tnand_sched: latency, NAND results, round-robin order,
// back-pressure, error flag and mid-operation reset.
module tb_tnand_sched;

    localparam int N_REQ = 4;
    localparam int TRITS = 4;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [N_REQ-1:0]         req_valid = '0;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ*2*TRITS-1:0] req_a = '0;
    logic [N_REQ*2*TRITS-1:0] req_b = '0;
    logic                     rsp_valid;
    logic                     rsp_ready = 1'b0;
    logic [2:0]               rsp_id;
    logic [2*TRITS-1:0]       rsp_data;
    logic                     rsp_err;

    int n_chk = 0;
    int n_err = 0;

    tnand_sched #(.N_REQ(N_REQ), .TRITS(TRITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait up to a bound for rsp_valid, sampling #1 after each rising edge; returns edge count.
    task automatic wait_rsp(output int edges);
        edges = 0;
        while (!rsp_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    // One full operation for a single requester with expected result checks.
    task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_data, input logic exp_err);
        int cyc;
        int edges;
        @(negedge clk);
        req_valid = '0;
        req_valid[idx] = 1'b1;
        req_a[idx*8 +: 8] = a;
        req_b[idx*8 +: 8] = b;
        #1;
        cyc = 0;
        while (!req_ready[idx] && cyc < 20) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk("grant", 32'(req_ready), 32'(1 << idx));
        @(posedge clk); #1;
        req_valid = '0;
        req_a = '0;  // operands must have been captured
        req_b = '0;
        chk("data_zero_run", 32'(rsp_data), 32'h0);
        wait_rsp(edges);
        chk("latency", 32'(edges), 32'(TRITS));
        chk("rsp_data", 32'(rsp_data), 32'(exp_data));
        chk("rsp_id", 32'(rsp_id), 32'(idx));
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", 32'(rsp_valid), 32'h0);
    endtask

    int order[5];
    int ng;
    int cyc;
    int edges;
    logic [7:0] held;

    initial begin
        // Reset state with a request already pending.
        req_valid = 4'b0001;
        #12;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_data", 32'(rsp_data), 32'h0);
        chk("rst_id", 32'(rsp_id), 32'h0);
        chk("rst_err", 32'(rsp_err), 32'h0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin with all requesters held valid and consumer always ready.
        @(negedge clk);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        ng = 0;
        cyc = 0;
        while (ng < 5 && cyc < 200) begin
            #1;
            chk("onehot", 32'($countones(req_ready) <= 1), 32'h1);
            for (int i = 0; i < N_REQ; i++)
                if (req_ready[i]) begin
                    order[ng] = i;
                    ng++;
                end
            if (ng == 5) req_valid = '0;
            @(negedge clk);
            cyc++;
        end
        chk("rr_count", 32'(ng), 32'd5);
        chk("rr_0", 32'(order[0]), 32'd0);
        chk("rr_1", 32'(order[1]), 32'd1);
        chk("rr_2", 32'(order[2]), 32'd2);
        chk("rr_3", 32'(order[3]), 32'd3);
        chk("rr_4", 32'(order[4]), 32'd0);
        req_valid = '0;
        cyc = 0;
        while ((rsp_valid || dut.state != 2'd0) && cyc < 20) begin
            @(negedge clk); #1;
            cyc++;
        end
        rsp_ready = 1'b0;

        // Directed NAND vectors.
        run_op(0, 8'b10_01_00_10, 8'b10_10_10_01, 8'b00_01_10_01, 1'b0);
        run_op(2, 8'b01010101,   8'b10101010,   8'b01010101,   1'b0);
        run_op(2, 8'b00000000,   8'b00000000,   8'b10101010,   1'b0);
        run_op(1, 8'b00_00_00_11, 8'b00_00_00_01, 8'b10_10_10_11, 1'b1);
        run_op(3, 8'b10101010,   8'b10101010,   8'b00000000,   1'b0);

        // Back-pressure: RESP held 3 cycles with a pending request.
        @(negedge clk);
        req_valid = 4'b0010;
        req_a[15:8] = 8'b00_01_10_01;
        req_b[15:8] = 8'b10_10_10_10;
        @(posedge clk); #1;
        req_valid = 4'b0100;
        req_a[23:16] = 8'b01_01_01_01;
        req_b[23:16] = 8'b01_01_01_01;
        wait_rsp(edges);
        chk("bp_latency", 32'(edges), 32'(TRITS));
        held = rsp_data;
        chk("bp_data", 32'(held), 32'(8'b10_01_00_01));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk("bp_stable", 32'(rsp_data), 32'(held));
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_id", 32'(rsp_id), 32'h1);
            chk("bp_noready", 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_hs_noready", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_bubble_valid", 32'(rsp_valid), 32'h0);
        chk("bp_accept", 32'(req_ready), 32'b0100);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(edges);
        chk("bp2_latency", 32'(edges), 32'(TRITS));
        chk("bp2_data", 32'(rsp_data), 32'(8'b01_01_01_01));
        chk("bp2_id", 32'(rsp_id), 32'h2);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Reset during RUN of requester 3 aborts it; requester 0 goes first afterwards.
        @(negedge clk);
        req_valid = 4'b1000;
        req_a[31:24] = 8'b01010101;
        req_b[31:24] = 8'b01010101;
        @(posedge clk); #1;
        req_valid = 4'b1001;
        req_a[7:0] = 8'b00_00_01_10;
        req_b[7:0] = 8'b10_10_10_10;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        chk("mid_rst_data", 32'(rsp_data), 32'h0);
        chk("mid_rst_id", 32'(rsp_id), 32'h0);
        chk("mid_rst_err", 32'(rsp_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(edges);
        chk("post_rst_latency", 32'(edges), 32'(TRITS));
        chk("post_rst_id", 32'(rsp_id), 32'h0);
        chk("post_rst_data", 32'(rsp_data), 32'(8'b10_10_01_00));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("no_stale_rsp", 32'(rsp_valid), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
